// File: rtl/i2s_serializer.sv
// i2s_serializer: turns one 18-bit stereo sample pair per frame into an
// I2S bit stream. The bit clock is i_clk/4 and there are 64 bit slots per frame.
// The upstream latch is asked for the next pair during slot 63, and the pair is
// captured on the tick that wraps the slot counter back to 0.
// Build option: define I2S_LEFT_JUSTIFIED_EN to select left-justified output
// (LRCK high = left, MSB in slot 0/32) instead of standard I2S.
module i2s_serializer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [17:0] i_data_l,
  input  logic [17:0] i_data_r,
  output logic        o_i2s_bclk,
  output logic        o_i2s_lrck,
  output logic        o_i2s_data,
  output logic        o_i2s_latch
);

  logic [1:0]  div_reg;
  logic [5:0]  bit_reg;
  logic [17:0] hold_l_reg;
  logic [17:0] hold_r_reg;
  logic        lrck_reg;
  logic        data_reg;
  logic        latch_reg;

  logic        tick;
  logic [5:0]  bit_next;
  logic        data_next;
  logic        lrck_next;
  logic [4:0]  l_idx;
  logic [4:0]  r_idx;

  // tick marks the bclk falling edge; every slot-level change happens here.
  assign tick     = (div_reg == 2'd3);
  assign bit_next = bit_reg + 6'd1;

`ifdef I2S_LEFT_JUSTIFIED_EN
  assign lrck_next = ~bit_next[5];
  assign l_idx     = 5'(6'd17 - bit_next);
  assign r_idx     = 5'(6'd49 - bit_next);
`else
  assign lrck_next = bit_next[5];
  assign l_idx     = 5'(6'd18 - bit_next);
  assign r_idx     = 5'(6'd50 - bit_next);
`endif

  // Select the data bit belonging to the slot being entered on this tick.
  always_comb begin
    data_next = 1'b0;
`ifdef I2S_LEFT_JUSTIFIED_EN
    // Slot 0 is entered on the capture tick itself, so the MSB bypasses the
    // holding register and comes straight from the input.
    if (bit_next == 6'd0) begin
      data_next = i_data_l[17];
    end else if (bit_next <= 6'd17) begin
      data_next = hold_l_reg[l_idx];
    end else if (bit_next >= 6'd32 && bit_next <= 6'd49) begin
      data_next = hold_r_reg[r_idx];
    end
`else
    // I2S delays the MSB by one slot after the LRCK transition.
    if (bit_next >= 6'd1 && bit_next <= 6'd18) begin
      data_next = hold_l_reg[l_idx];
    end else if (bit_next >= 6'd33 && bit_next <= 6'd50) begin
      data_next = hold_r_reg[r_idx];
    end
`endif
  end

  // Prescaler, slot counter, sample capture and registered serial outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_reg    <= 2'd0;
      bit_reg    <= 6'd0;
      hold_l_reg <= 18'd0;
      hold_r_reg <= 18'd0;
      lrck_reg   <= 1'b0;
      data_reg   <= 1'b0;
      latch_reg  <= 1'b0;
    end else begin
      div_reg <= div_reg + 2'd1;
      if (tick) begin
        bit_reg   <= bit_next;
        lrck_reg  <= lrck_next;
        data_reg  <= data_next;
        latch_reg <= (bit_next == 6'd63);
        // Capture coincides with the latch request falling edge.
        if (bit_reg == 6'd63) begin
          hold_l_reg <= i_data_l;
          hold_r_reg <= i_data_r;
        end
      end
    end
  end

  assign o_i2s_bclk  = div_reg[1];
  assign o_i2s_lrck  = lrck_reg;
  assign o_i2s_data  = data_reg;
  assign o_i2s_latch = latch_reg;

endmodule

// File: tb/tb_i2s_serializer.sv
// Bench for i2s_serializer: a stimulus process drives sample words and reset,
// pushing the expected per-slot {lrck, data, latch} into a queue; a monitor
// pops one entry at every bclk rising edge and compares.
module tb_i2s_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] data_l = 18'd0;
  logic [17:0] data_r = 18'd0;
  logic        bclk, lrck, sdata, latch;

  typedef struct packed {
    logic [5:0] slot;
    logic       lrck;
    logic       data;
    logic       latch;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  i2s_serializer dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_data_l    (data_l),
    .i_data_r    (data_r),
    .o_i2s_bclk  (bclk),
    .o_i2s_lrck  (lrck),
    .o_i2s_data  (sdata),
    .o_i2s_latch (latch)
  );

  // 10-unit clock period.
  initial forever #5 clk = ~clk;

  // Clocks since the last reset edge: after edge n of a frame, slot = cyc/4 mod 64.
  initial forever begin
    @(posedge clk);
    if (rst) cyc = 0;
    else cyc = cyc + 1;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected output for each slot of one frame carrying words l/r.
  task automatic push_frame(input logic [17:0] l, input logic [17:0] r, input bit first);
    exp_t e;
    for (int s = 0; s < 64; s++) begin
      e.slot  = 6'(s);
      e.latch = (s == 63);
      e.data  = 1'b0;
`ifdef I2S_LEFT_JUSTIFIED_EN
      e.lrck = (s < 32);
      if (s <= 17) e.data = l[17 - s];
      else if (s >= 32 && s <= 49) e.data = r[49 - s];
`else
      e.lrck = (s >= 32);
      if (s >= 1 && s <= 18) e.data = l[18 - s];
      else if (s >= 33 && s <= 50) e.data = r[50 - s];
`endif
      // The first slot after reset shows the cleared output registers.
      if (first && s == 0) begin
        e.lrck = 1'b0;
        e.data = 1'b0;
      end
      sb.push_back(e);
    end
  endtask

  task automatic goto(input int c);
    while (cyc != c) @(negedge clk);
  endtask

  // Monitor: one comparison per slot, taken at the bclk rising edge.
  initial begin
    logic bclk_prev;
    exp_t e;
    bclk_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bclk && !bclk_prev) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL slot_unexpected: got lrck=%b data=%b latch=%b, expected no output", lrck, sdata, latch);
        end else begin
          e = sb.pop_front();
          if ({lrck, sdata, latch} !== {e.lrck, e.data, e.latch}) begin
            n_fail++;
            $display("FAIL slot%0d: got lrck=%b data=%b latch=%b, expected lrck=%b data=%b latch=%b",
                     e.slot, lrck, sdata, latch, e.lrck, e.data, e.latch);
          end else begin
            $display("slot %0d lrck=%b data=%b latch=%b ok", e.slot, lrck, sdata, latch);
          end
        end
      end
      bclk_prev = bclk;
    end
  end

  // Stimulus.
  initial begin
    int waited;
    rst    = 1'b1;
    data_l = 18'h2AAAA;
    data_r = 18'h15555;
    repeat (3) @(negedge clk);
    check("reset_bclk",  32'(bclk),  32'd0);
    check("reset_lrck",  32'(lrck),  32'd0);
    check("reset_data",  32'(sdata), 32'd0);
    check("reset_latch", 32'(latch), 32'd0);

    // Frame 0 after reset carries zero words; later frames carry captured inputs.
    push_frame(18'h00000, 18'h00000, 1'b1);
    push_frame(18'h2AAAA, 18'h15555, 1'b0);
    push_frame(18'h2AAAA, 18'h15555, 1'b0);
    push_frame(18'h3FFFF, 18'h12345, 1'b0);
    push_frame(18'h00001, 18'h20000, 1'b0);
    push_frame(18'h00001, 18'h20000, 1'b0);
    rst = 1'b0;

    // Alternating patterns held for frames 1 and 2; switch to all-ones in frame 2.
    goto(2 * 256 + 5 * 4 + 1);
    data_l = 18'h3FFFF;
    data_r = 18'h12345;
    // Change inputs in slot 10 of the all-ones frame; that frame must not change.
    goto(3 * 256 + 10 * 4 + 1);
    data_l = 18'h00001;
    data_r = 18'h20000;

    // One-clock reset in slot 40 of frame 5.
    goto(5 * 256 + 40 * 4 + 3);
    check("pre_reset_lrck", 32'(lrck), 32'(`ifdef I2S_LEFT_JUSTIFIED_EN 0 `else 1 `endif));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    data_l = 18'h2F0F1;
    data_r = 18'h0A5C3;
    push_frame(18'h00000, 18'h00000, 1'b1);
    push_frame(18'h2F0F1, 18'h0A5C3, 1'b0);
    check("abort_bclk",  32'(bclk),  32'd0);
    check("abort_lrck",  32'(lrck),  32'd0);
    check("abort_data",  32'(sdata), 32'd0);
    check("abort_latch", 32'(latch), 32'd0);

    // First latch pulse must rise 252 clocks after the reset edge.
    waited = 0;
    while (!latch && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check("latch_delay", 32'(cyc), 32'd252);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("latch_width_hi", 32'(latch), 32'd1);
    @(negedge clk);
    check("latch_width_lo", 32'(latch), 32'd0);
    check("latch_end_lrck", 32'(lrck), 32'(`ifdef I2S_LEFT_JUSTIFIED_EN 1 `else 0 `endif));

    goto(2 * 256 + 1);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
